// File: rtl/addsub_serial_nbits.sv
// ---------------------------------------------------------------------------
// addsub_serial_nbits
//   Digit-serial signed/unsigned adder/subtractor. Each BUSY cycle processes
//   `digit` bits, LSB first, so a `width`-bit operation takes width/digit
//   cycles. Operands come in and the result goes out on valid/ready
//   handshakes.
//
// Optional feature macro:
//   ADDSUB_SATURATE_EN - when defined, s_o is clamped to the signed limit in
//                        DONE if signed overflow occurred.
//
// Parameters:
//   width   operand/result width (>= 1)
//   digit   bits processed per cycle (1..width, must divide width)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   valid_i  operands valid          ready_o  block can accept operands
//   a_i      operand A               b_i      operand B
//   sub_i    0: A+B, 1: A-B
//   valid_o  result valid            ready_i  downstream accepts result
//   s_o      sum / difference
//   cout_o   carry out (for subtraction 1 = no borrow)
//   ovf_o    two's-complement signed overflow
// ---------------------------------------------------------------------------
module addsub_serial_nbits #(
    parameter int width = 8,
    parameter int digit = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [width-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int N     = (digit > 0) ? width / digit : 1;
    localparam int CNT_W = $clog2(N + 1);

    if (width < 1 || digit < 1 || digit > width || (width % digit) != 0) begin : g_bad_param
        $error("addsub_serial_nbits: need 1 <= digit <= width and width %% digit == 0");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [width-1:0]   a_q, b_q, s_q;
    logic               carry_q, ovf_q;

    logic               accept, step, last, finish;
    logic [digit:0]     sum;
    logic [width+digit-1:0] s_ext;

    assign accept = (state_q == IDLE) && valid_i;
    assign step   = (state_q == BUSY);
    assign last   = (cnt_q == CNT_W'(N - 1));
    assign finish = (state_q == DONE) && ready_i;

    // One digit of the ripple: low digit of A and B' plus incoming carry.
    assign sum   = {1'b0, a_q[digit-1:0]} + {1'b0, b_q[digit-1:0]} + {{digit{1'b0}}, carry_q};
    // New digit enters at the MSB end; written as a wide concat so that
    // digit == width needs no special case.
    assign s_ext = {sum[digit-1:0], s_q};

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = BUSY;
            BUSY:    if (last)          state_d = DONE;
            DONE:    if (finish)        state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;        // +1 completes the two's complement of B
            ovf_q   <= 1'b0;
        end else if (step) begin
            cnt_q   <= cnt_q + 1'b1;
            a_q     <= a_q >> digit;
            b_q     <= b_q >> digit;
            s_q     <= s_ext[width+digit-1:digit];
            carry_q <= sum[digit];
            // In the last step the operand MSBs sit at bit digit-1.
            if (last)
                ovf_q <= (a_q[digit-1] == b_q[digit-1]) && (sum[digit-1] != a_q[digit-1]);
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign cout_o  = carry_q;
    assign ovf_o   = ovf_q;

`ifdef ADDSUB_SATURATE_EN
    // On overflow the wrapped sum has the wrong sign, so its MSB tells the
    // overflow direction: MSB=1 means positive overflow -> 0x7F..,
    // MSB=0 means negative overflow -> 0x80..
    logic [width-1:0] s_sat;
    always_comb begin
        s_sat = s_q;
        if (state_q == DONE && ovf_q) begin
            for (int i = 0; i < width - 1; i++) s_sat[i] = s_q[width-1];
            s_sat[width-1] = ~s_q[width-1];
        end
    end
    assign s_o = s_sat;
`else
    assign s_o = s_q;
`endif

endmodule

// File: tb/tb_addsub_serial_nbits.sv
// Self-checking bench for addsub_serial_nbits: directed vector table on the
// width=8/digit=2 instance, hand-written back-pressure and reset sequences,
// and a random sweep over digit=1/4/8 (width 8) and width=16/digit=4.
module tb_addsub_serial_nbits;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- main DUT (width 8, digit 2) ----------------
    logic       rst_n;
    logic       valid, ready_o, sub, valid_o, ready_i, cout, ovf;
    logic [7:0] a, b, s;

    addsub_serial_nbits #(.width(8), .digit(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready_o),
        .a_i(a), .b_i(b), .sub_i(sub), .valid_o(valid_o), .ready_i(ready_i),
        .s_o(s), .cout_o(cout), .ovf_o(ovf)
    );

    // ---------------- sweep DUTs ----------------
    logic             sw_valid, sw_sub;
    logic [7:0]       sw_a, sw_b;
    logic [2:0]       sw_rdy, sw_vld, sw_cout, sw_ovf;
    logic [2:0][7:0]  sw_s;

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int D = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
        addsub_serial_nbits #(.width(8), .digit(D)) u (
            .clk_i(clk), .rst_ni(rst_n), .valid_i(sw_valid), .ready_o(sw_rdy[gi]),
            .a_i(sw_a), .b_i(sw_b), .sub_i(sw_sub), .valid_o(sw_vld[gi]), .ready_i(1'b1),
            .s_o(sw_s[gi]), .cout_o(sw_cout[gi]), .ovf_o(sw_ovf[gi])
        );
    end

    logic        w_valid, w_rdy, w_sub, w_vld, w_cout, w_ovf;
    logic [15:0] w_a, w_b, w_s;

    addsub_serial_nbits #(.width(16), .digit(4)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(w_valid), .ready_o(w_rdy),
        .a_i(w_a), .b_i(w_b), .sub_i(w_sub), .valid_o(w_vld), .ready_i(1'b1),
        .s_o(w_s), .cout_o(w_cout), .ovf_o(w_ovf)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        v;
    } res_t;

    function automatic res_t ref_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                                    input logic sv);
        res_t        r;
        logic [16:0] mask, bb, full;
        mask = (17'd1 << w) - 17'd1;
        bb   = (sv ? ~{1'b0, bv} : {1'b0, bv}) & mask;
        full = {1'b0, av} + bb + {16'd0, sv};
        r.s  = full[15:0] & mask[15:0];
        r.c  = full[w];
        r.v  = (av[w-1] == bb[w-1]) && (r.s[w-1] != av[w-1]);
`ifdef ADDSUB_SATURATE_EN
        if (r.v) r.s = av[w-1] ? (16'd1 << (w - 1)) : (mask[15:0] >> 1);
`endif
        return r;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] a, b;
        logic       sub;
        logic [7:0] s;     // wrapped result
        logic       c, v;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [7:0] exp_s(input vec_t t);
`ifdef ADDSUB_SATURATE_EN
        if (t.v) return t.a[7] ? 8'h80 : 8'h7F;
`endif
        return t.s;
    endfunction

    // Drive one operation at a negedge with the DUT idle; returns the number
    // of edges after the accept edge until valid_o is seen (-1 on timeout).
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                         output int lat);
        a = av; b = bv; sub = sv; valid = 1'b1;
        @(negedge clk);            // accept edge e0 has passed
        valid = 1'b0;
        check("busy_ready_o", ready_o, 1'b0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int   lat;
        bit   seen_valid;
        int   sw_lat[4];
        res_t e8, e16;

        tbl[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[7] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[9] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0; valid = 1'b0; a = '0; b = '0; sub = 1'b0; ready_i = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0;
        w_valid = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_s_o",     s,       8'h00);
        check("rst_cout_o",  cout,    1'b0);
        check("rst_ovf_o",   ovf,     1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors, back to back with ready_i high
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, lat);
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_s", i),       s,    exp_s(tbl[i]));
            check($sformatf("vec%0d_cout", i),    cout, tbl[i].c);
            check($sformatf("vec%0d_ovf", i),     ovf,  tbl[i].v);
            @(negedge clk);        // completion edge eR has passed
            check($sformatf("vec%0d_ready_after", i), ready_o, 1'b1);
            check($sformatf("vec%0d_valid_after", i), valid_o, 1'b0);
        end

        // back-pressure: hold result for 5 cycles, poke inputs meanwhile
        ready_i = 1'b0;
        do_op(8'h12, 8'h34, 1'b0, lat);
        check("bp_latency", lat, 4);
        for (int k = 0; k < 5; k++) begin
            a = 8'hA0 + 8'(k); b = 8'h0F; sub = k[0]; valid = 1'b1;
            check($sformatf("bp%0d_valid_o", k), valid_o, 1'b1);
            check($sformatf("bp%0d_ready_o", k), ready_o, 1'b0);
            check($sformatf("bp%0d_s", k),       s,       8'h46);
            check($sformatf("bp%0d_cout", k),    cout,    1'b0);
            check($sformatf("bp%0d_ovf", k),     ovf,     1'b0);
            @(negedge clk);
        end
        // release: completion at eR, new op (0x01+0x01) accepted at eR+1
        ready_i = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0; valid = 1'b1;
        @(negedge clk);
        check("bp_ready_after_eR", ready_o, 1'b1);
        check("bp_valid_after_eR", valid_o, 1'b0);
        @(negedge clk);
        valid = 1'b0;
        check("bp_accept_eR1", ready_o, 1'b0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = k;
                break;
            end
        end
        check("bp_next_latency", lat, 4);
        check("bp_next_s", s, 8'h02);
        @(negedge clk);

        // reset in the middle of BUSY
        a = 8'h7F; b = 8'h01; sub = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);            // step 1 done
        @(posedge clk);            // step 2
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready_o", ready_o, 1'b1);
        check("mid_rst_valid_o", valid_o, 1'b0);
        check("mid_rst_s_o",     s,       8'h00);
        check("mid_rst_cout_o",  cout,    1'b0);
        check("mid_rst_ovf_o",   ovf,     1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid_o) seen_valid = 1'b1;
        end
        check("mid_rst_no_valid", seen_valid, 1'b0);
        do_op(8'h12, 8'h34, 1'b0, lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_s", s, 8'h46);
        @(negedge clk);

        // random sweep over digit sizes; all sweep DUTs accept at the same edge
        for (int it = 0; it < 20; it++) begin
            sw_a = 8'($urandom); sw_b = 8'($urandom); sw_sub = 1'($urandom);
            w_a = 16'($urandom); w_b = 16'($urandom); w_sub = 1'($urandom);
            e8  = ref_op(8,  {8'h00, sw_a}, {8'h00, sw_b}, sw_sub);
            e16 = ref_op(16, w_a, w_b, w_sub);
            sw_valid = 1'b1; w_valid = 1'b1;
            @(negedge clk);
            sw_valid = 1'b0; w_valid = 1'b0;
            for (int j = 0; j < 4; j++) sw_lat[j] = -1;
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                for (int j = 0; j < 3; j++) begin
                    if (sw_vld[j] && sw_lat[j] < 0) begin
                        sw_lat[j] = k;
                        check($sformatf("sw%0d_d%0d_s", it, j), sw_s[j], e8.s[7:0]);
                        check($sformatf("sw%0d_d%0d_cout", it, j), sw_cout[j], e8.c);
                        check($sformatf("sw%0d_d%0d_ovf", it, j), sw_ovf[j], e8.v);
                    end
                end
                if (w_vld && sw_lat[3] < 0) begin
                    sw_lat[3] = k;
                    check($sformatf("sw%0d_w16_s", it), w_s, e16.s);
                    check($sformatf("sw%0d_w16_cout", it), w_cout, e16.c);
                    check($sformatf("sw%0d_w16_ovf", it), w_ovf, e16.v);
                end
            end
            check($sformatf("sw%0d_d1_latency", it),  sw_lat[0], 8);
            check($sformatf("sw%0d_d4_latency", it),  sw_lat[1], 2);
            check($sformatf("sw%0d_d8_latency", it),  sw_lat[2], 1);
            check($sformatf("sw%0d_w16_latency", it), sw_lat[3], 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
